// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI execute-in-place read sequencer: FSM states,
// SPI-core register map, CTRL bit fields and register-bus command helpers.
package spi_xip_pkg;

  localparam int ADR_W = 5;

  typedef enum logic [3:0] {
    IDLE,
    WR_TX1,
    WR_TX0,
    WR_DIV,
    WR_SS,
    WR_CTRL,
    POLL,
    RD_RX,
    CLR_SS,
    DONE,
    TO_CTRL
  } xip_state_e;

  localparam logic [ADR_W-1:0] REG_RX0     = 5'h00;
  localparam logic [ADR_W-1:0] REG_TX0     = 5'h00;
  localparam logic [ADR_W-1:0] REG_TX1     = 5'h04;
  localparam logic [ADR_W-1:0] REG_CTRL    = 5'h10;
  localparam logic [ADR_W-1:0] REG_DIVIDER = 5'h14;
  localparam logic [ADR_W-1:0] REG_SS      = 5'h18;

  localparam int CTRL_ASS_BIT    = 13;
  localparam int CTRL_TX_NEG_BIT = 10;
  localparam int CTRL_GO_BIT     = 8;
  localparam logic [6:0] CTRL_CHAR_LEN = 7'd64;

  // 64-bit frame: 8-bit opcode + 24-bit address out, 32 bits of data back
  localparam logic [31:0] CTRL_START = (32'd1 << CTRL_ASS_BIT) | (32'd1 << CTRL_TX_NEG_BIT)
                                     | (32'd1 << CTRL_GO_BIT) | {25'd0, CTRL_CHAR_LEN};

  localparam logic [7:0] FLASH_READ_OP = 8'h03;

  typedef struct packed {
    logic             req;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [31:0]      wdata;
  } bus_cmd_t;

  localparam bus_cmd_t CMD_NONE = '0;

  function automatic bus_cmd_t cmd_wr(input logic [ADR_W-1:0] adr, input logic [31:0] data);
    bus_cmd_t c;
    c.req   = 1'b1;
    c.we    = 1'b1;
    c.adr   = adr;
    c.wdata = data;
    return c;
  endfunction

  function automatic bus_cmd_t cmd_rd(input logic [ADR_W-1:0] adr);
    bus_cmd_t c;
    c.req   = 1'b1;
    c.we    = 1'b0;
    c.adr   = adr;
    c.wdata = '0;
    return c;
  endfunction

endpackage

// File: rtl/spi_xip_seq_if.sv
// Register bus between the sequencer and the SPI core (Wishbone-style
// single-access handshake).
interface spi_xip_seq_if;
  import spi_xip_pkg::*;

  logic [ADR_W-1:0] adr;
  logic [31:0]      dat_o;
  logic [31:0]      dat_i;
  logic [3:0]       sel;
  logic             we;
  logic             stb;
  logic             cyc;
  logic             ack;
  logic             err;

  modport master (output adr, dat_o, sel, we, stb, cyc, input dat_i, ack, err);
  modport slave  (input adr, dat_o, sel, we, stb, cyc, output dat_i, ack, err);
endinterface

// File: rtl/spi_xip_busm.sv
// Single-access register-bus master: holds one request on the bus until the
// core acks or errors; completion is visible in the same cycle as the response.
module spi_xip_busm
  import spi_xip_pkg::*;
(
  input  logic              req,
  input  logic              we,
  input  logic [ADR_W-1:0]  adr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  spi_xip_seq_if.master     bus
);

  assign bus.stb   = req;
  assign bus.cyc   = req;
  assign bus.we    = req & we;
  assign bus.adr   = adr;
  assign bus.dat_o = wdata;
  assign bus.sel   = req ? 4'hf : 4'h0;

  assign done  = req & bus.ack;
  assign err   = req & bus.err;
  assign rdata = bus.dat_i;

endmodule

// File: rtl/spi_xip_seq.sv
// APB front end for an SPI flash XIP window: non-window accesses pass straight
// to the SPI core, window reads run a full SPI read transaction.
// Optional poll timeout enabled by defining SPI_XIP_SEQ_TIMEOUT_EN.
module spi_xip_seq
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE  = 32'h3000_0000,
  parameter logic [31:0] FLASH_LIMIT = 32'h3fff_ffff,
  parameter logic [15:0] SPI_DIV     = 16'h0001,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [4:0]  spi_adr,
  output logic [31:0] spi_dat_o,
  input  logic [31:0] spi_dat_i,
  output logic [3:0]  spi_sel,
  output logic        spi_we,
  output logic        spi_stb,
  output logic        spi_cyc,
  input  logic        spi_ack,
  input  logic        spi_err
);

  xip_state_e  state_reg;
  bus_cmd_t    cmd_reg;
  logic [31:0] data_reg;
  logic        err_reg;

  logic        bus_done;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic [31:0] rx_swapped;
  logic        xip_hit;
  logic        xip_rd_start;

  spi_xip_seq_if xbus ();

  assign xbus.dat_i = spi_dat_i;
  assign xbus.ack   = spi_ack;
  assign xbus.err   = spi_err;

  spi_xip_busm u_busm (
    .req   (cmd_reg.req),
    .we    (cmd_reg.we),
    .adr   (cmd_reg.adr),
    .wdata (cmd_reg.wdata),
    .done  (bus_done),
    .rdata (bus_rdata),
    .err   (bus_err),
    .bus   (xbus)
  );

  assign xip_hit      = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_LIMIT);
  assign xip_rd_start = in_psel && in_penable && !in_pwrite && xip_hit;

  // Flash shifts the first-addressed byte out first, which lands in RX0[31:24]
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_swap
      assign rx_swapped[8*gi +: 8] = bus_rdata[8*(3-gi) +: 8];
    end
  endgenerate

`ifdef SPI_XIP_SEQ_TIMEOUT_EN
  logic [31:0] poll_cnt_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cmd_reg   <= CMD_NONE;
      data_reg  <= '0;
      err_reg   <= 1'b0;
`ifdef SPI_XIP_SEQ_TIMEOUT_EN
      poll_cnt_reg <= '0;
`endif
    end else if (bus_err) begin
      state_reg <= DONE;
      cmd_reg   <= CMD_NONE;
      data_reg  <= '0;
      err_reg   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xip_rd_start) begin
            // The TX1 command word is the only place the APB address is kept
            state_reg <= WR_TX1;
            cmd_reg   <= cmd_wr(REG_TX1, {FLASH_READ_OP, in_paddr[23:2], 2'b00});
            data_reg  <= '0;
            err_reg   <= 1'b0;
          end
        end
        WR_TX1: if (bus_done) begin
          state_reg <= WR_TX0;
          cmd_reg   <= cmd_wr(REG_TX0, 32'd0);
        end
        WR_TX0: if (bus_done) begin
          state_reg <= WR_DIV;
          cmd_reg   <= cmd_wr(REG_DIVIDER, {16'd0, SPI_DIV});
        end
        WR_DIV: if (bus_done) begin
          state_reg <= WR_SS;
          cmd_reg   <= cmd_wr(REG_SS, 32'd1);
        end
        WR_SS: if (bus_done) begin
          state_reg <= WR_CTRL;
          cmd_reg   <= cmd_wr(REG_CTRL, CTRL_START);
        end
        WR_CTRL: if (bus_done) begin
          state_reg <= POLL;
          cmd_reg   <= cmd_rd(REG_CTRL);
`ifdef SPI_XIP_SEQ_TIMEOUT_EN
          poll_cnt_reg <= '0;
`endif
        end
        POLL: begin
          if (bus_done && !bus_rdata[CTRL_GO_BIT]) begin
            state_reg <= RD_RX;
            cmd_reg   <= cmd_rd(REG_RX0);
          end
`ifdef SPI_XIP_SEQ_TIMEOUT_EN
          else if (poll_cnt_reg == 32'(TIMEOUT_CYC - 1)) begin
            state_reg <= TO_CTRL;
            cmd_reg   <= cmd_wr(REG_CTRL, 32'd0);
            err_reg   <= 1'b1;
          end else begin
            poll_cnt_reg <= poll_cnt_reg + 32'd1;
          end
`endif
        end
        TO_CTRL: if (bus_done) begin
          state_reg <= CLR_SS;
          cmd_reg   <= cmd_wr(REG_SS, 32'd0);
        end
        RD_RX: if (bus_done) begin
          state_reg <= CLR_SS;
          data_reg  <= rx_swapped;
          cmd_reg   <= cmd_wr(REG_SS, 32'd0);
        end
        CLR_SS: if (bus_done) begin
          state_reg <= DONE;
          cmd_reg   <= CMD_NONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          cmd_reg   <= CMD_NONE;
        end
      endcase
    end
  end

  always_comb begin
    in_pready  = 1'b0;
    in_pslverr = 1'b0;
    in_prdata  = '0;
    spi_adr    = '0;
    spi_dat_o  = '0;
    spi_sel    = '0;
    spi_we     = 1'b0;
    spi_stb    = 1'b0;
    spi_cyc    = 1'b0;
    if (!reset) begin
      if (state_reg == IDLE) begin
        if (!xip_hit) begin
          spi_adr    = in_paddr[4:0];
          spi_dat_o  = in_pwdata;
          spi_sel    = in_pstrb;
          spi_we     = in_pwrite;
          spi_stb    = in_psel;
          spi_cyc    = in_penable;
          in_pready  = spi_ack;
          in_pslverr = spi_err;
          in_prdata  = spi_dat_i;
        end else if (in_psel && in_penable && in_pwrite) begin
          // Flash window is read-only: reject writes at once
          in_pready  = 1'b1;
          in_pslverr = 1'b1;
        end
      end else if (state_reg == DONE) begin
        in_pready  = 1'b1;
        in_pslverr = err_reg;
        in_prdata  = data_reg;
      end else begin
        spi_adr   = xbus.adr;
        spi_dat_o = xbus.dat_o;
        spi_sel   = xbus.sel;
        spi_we    = xbus.we;
        spi_stb   = xbus.stb;
        spi_cyc   = xbus.cyc;
      end
    end
  end

endmodule

// File: tb/tb_spi_xip_seq.sv
// Directed bench for spi_xip_seq: an SPI-core responder checks every register
// access against a queue of expected accesses; APB results use a second queue.
module tb_spi_xip_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic        in_pwrite = 1'b0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = '0;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  always #5 clock = ~clock;

  spi_xip_seq_if sbus ();

  spi_xip_seq #(.TIMEOUT_CYC(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_paddr   (in_paddr),
    .in_psel    (in_psel),
    .in_penable (in_penable),
    .in_pwrite  (in_pwrite),
    .in_pwdata  (in_pwdata),
    .in_pstrb   (in_pstrb),
    .in_pready  (in_pready),
    .in_prdata  (in_prdata),
    .in_pslverr (in_pslverr),
    .spi_adr    (sbus.adr),
    .spi_dat_o  (sbus.dat_o),
    .spi_dat_i  (sbus.dat_i),
    .spi_sel    (sbus.sel),
    .spi_we     (sbus.we),
    .spi_stb    (sbus.stb),
    .spi_cyc    (sbus.cyc),
    .spi_ack    (sbus.ack),
    .spi_err    (sbus.err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [4:0]  adr;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } apb_exp_t;

  txn_t     exp_q[$];
  apb_exp_t apb_q[$];
  txn_t     t;

  logic [31:0] flash_word = '0;
  int          go_left = 0;
  logic        go_stuck = 1'b0;
  logic        err_arm = 1'b0;
  logic [4:0]  err_adr = '0;
  int          ctrl_reads = 0;
  int          rx_reads = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [4:0] adr, input logic [31:0] data);
    exp_q.push_back('{1'b1, 4'hf, adr, data});
  endtask

  task automatic push_r(input logic [4:0] adr);
    exp_q.push_back('{1'b0, 4'hf, adr, 32'd0});
  endtask

  task automatic push_xip_start(input logic [31:0] tx1);
    push_w(5'h04, tx1);
    push_w(5'h00, 32'd0);
    push_w(5'h14, 32'd1);
    push_w(5'h18, 32'd1);
    push_w(5'h10, 32'h0000_2540);
  endtask

  task automatic push_xip_finish(input int polls);
    for (int i = 0; i <= polls; i++) push_r(5'h10);
    push_r(5'h00);
    push_w(5'h18, 32'd0);
  endtask

  // SPI-core responder: checks each access when it is acked, replies one cycle later
  always @(negedge clock) begin
    if (reset) begin
      sbus.ack   = 1'b0;
      sbus.err   = 1'b0;
      sbus.dat_i = '0;
    end else if (sbus.ack || sbus.err) begin
      sbus.ack = 1'b0;
      sbus.err = 1'b0;
    end else if (sbus.stb && sbus.cyc) begin
      $display("spi we=%0d adr=%h sel=%h wdata=%h", sbus.we, sbus.adr, sbus.sel, sbus.dat_o);
      if (!sbus.we && sbus.adr == 5'h10) ctrl_reads++;
      if (!sbus.we && sbus.adr == 5'h00) rx_reads++;
      if (!(go_stuck && !sbus.we && sbus.adr == 5'h10)) begin
        chk("spi_access_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          chk("spi_we_sel_adr", {22'd0, sbus.we, sbus.sel, sbus.adr}, {22'd0, t.we, t.sel, t.adr});
          if (t.we) chk("spi_wdata", sbus.dat_o, t.data);
        end
      end
      if (!sbus.we && sbus.adr == 5'h10) begin
        if (go_stuck || go_left > 0) begin
          sbus.dat_i = 32'h0000_2540;
          if (go_left > 0) go_left--;
        end else begin
          sbus.dat_i = 32'h0000_2440;
        end
      end else if (!sbus.we && sbus.adr == 5'h00) begin
        sbus.dat_i = flash_word;
      end else begin
        sbus.dat_i = 32'hA5A5_5A5A;
      end
      if (err_arm && sbus.we && sbus.adr == err_adr) begin
        sbus.err = 1'b1;
        err_arm  = 1'b0;
      end else begin
        sbus.ack = 1'b1;
      end
    end
  end

  task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                     input logic [3:0] strb, output logic [31:0] rd, output logic se,
                     output int waits);
    @(posedge clock); #1;
    in_paddr = addr; in_pwrite = wr; in_pwdata = wd; in_pstrb = strb;
    in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    waits = 0;
    rd = 'x;
    se = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock); #1;
      if (in_pready) begin
        rd = in_prdata;
        se = in_pslverr;
        break;
      end
      waits++;
    end
    chk("apb_completed", (waits < 3000), 1);
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  task automatic apb_check(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic chk_rd, output int waits);
    logic [31:0] rd;
    logic        se;
    apb_exp_t    e;
    apb_q.push_back('{exp_rd, exp_err, chk_rd});
    apb(addr, wr, wd, strb, rd, se, waits);
    e = apb_q.pop_front();
    $display("apb %s addr=%h wr=%0d prdata=%h pslverr=%0d waits=%0d", tag, addr, wr, rd, se, waits);
    if (e.chk_rd) chk({tag, "_prdata"}, rd, e.rd);
    chk({tag, "_pslverr"}, {31'd0, se}, {31'd0, e.err});
  endtask

  initial begin
    int w;
    int c0;
    int r0;

    // Reset with a pass-through write pending: everything must stay quiet
    in_paddr = 32'h0000_0010; in_psel = 1'b1; in_penable = 1'b1; in_pwrite = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_pready", {31'd0, in_pready}, 0);
    chk("rst_pslverr", {31'd0, in_pslverr}, 0);
    chk("rst_prdata", in_prdata, 0);
    chk("rst_stb_cyc_we", {29'd0, sbus.stb, sbus.cyc, sbus.we}, 0);
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    reset = 1'b0;

    // Basic XIP read
    flash_word = 32'h1122_3344; go_left = 0; c0 = ctrl_reads;
    push_xip_start(32'h0300_0104);
    push_xip_finish(0);
    apb_check("xip_104", 32'h3000_0104, 1'b0, 32'd0, 4'h0, 32'h4433_2211, 1'b0, 1'b1, w);
    chk("xip_104_ctrl_reads", ctrl_reads - c0, 1);
    @(negedge clock); #1;
    chk("done_one_cycle", {31'd0, in_pready}, 0);

    // Just below the window: pass-through
    exp_q.push_back('{1'b0, 4'h0, 5'h1c, 32'd0});
    apb_check("pt_rd", 32'h2fff_fffc, 1'b0, 32'd0, 4'h0, 32'hA5A5_5A5A, 1'b0, 1'b1, w);
    exp_q.push_back('{1'b1, 4'h3, 5'h08, 32'hDEAD_BEEF});
    apb_check("pt_wr", 32'h2000_0008, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'd0, 1'b0, 1'b0, w);

    // Last word of the window
    flash_word = 32'hA1B2_C3D4;
    push_xip_start(32'h03ff_fffc);
    push_xip_finish(0);
    apb_check("xip_top", 32'h3fff_fffc, 1'b0, 32'd0, 4'h0, 32'hD4C3_B2A1, 1'b0, 1'b1, w);

    // XIP write: error in access phase, no SPI traffic
    apb_check("xip_wr", 32'h3000_0000, 1'b1, 32'h1234_5678, 4'hf, 32'd0, 1'b1, 1'b0, w);
    chk("xip_wr_waits", w, 0);
    @(negedge clock); #1;
    chk("xip_wr_pready_drop", {31'd0, in_pready}, 0);

    // GO stays set for 37 polls
    flash_word = 32'hCAFE_F00D; go_left = 37; c0 = ctrl_reads; r0 = rx_reads;
    push_xip_start(32'h0300_0040);
    push_xip_finish(37);
    apb_check("xip_poll37", 32'h3000_0040, 1'b0, 32'd0, 4'h0, 32'h0DF0_FECA, 1'b0, 1'b1, w);
    chk("poll37_ctrl_reads", ctrl_reads - c0, 38);
    chk("poll37_rx_reads", rx_reads - r0, 1);

    // Error on the DIVIDER write aborts before CTRL
    err_arm = 1'b1; err_adr = 5'h14;
    push_w(5'h04, 32'h0300_0080);
    push_w(5'h00, 32'd0);
    push_w(5'h14, 32'd1);
    apb_check("xip_err_div", 32'h3000_0080, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1, w);
    repeat (3) @(posedge clock);
    chk("err_div_consumed", {31'd0, err_arm}, 0);
    chk("err_div_no_more", exp_q.size(), 0);

    // Reset while polling
    go_stuck = 1'b1; c0 = ctrl_reads;
    push_xip_start(32'h0300_0200);
    @(posedge clock); #1;
    in_paddr = 32'h3000_0200; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    for (int i = 0; i < 500 && ctrl_reads < c0 + 3; i++) @(negedge clock);
    chk("poll_reached", {31'd0, (ctrl_reads - c0 >= 3)}, 1);
    @(posedge clock); #1;
    reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0;
    @(negedge clock); #1;
    chk("mid_rst_apb", {in_prdata[30:0] | 31'd0, in_pready | in_pslverr}, 0);
    chk("mid_rst_prdata", in_prdata, 0);
    chk("mid_rst_spi", {29'd0, sbus.stb, sbus.cyc, sbus.we}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    go_stuck = 1'b0;
    @(negedge clock); #1;
    chk("post_rst_spi", {29'd0, sbus.stb, sbus.cyc, sbus.we}, 0);
    chk("post_rst_pready", {31'd0, in_pready}, 0);
    chk("post_rst_queue", exp_q.size(), 0);
    flash_word = 32'h0102_0304; go_left = 2;
    push_xip_start(32'h0300_0200);
    push_xip_finish(2);
    apb_check("xip_after_rst", 32'h3000_0200, 1'b0, 32'd0, 4'h0, 32'h0403_0201, 1'b0, 1'b1, w);

`ifdef SPI_XIP_SEQ_TIMEOUT_EN
    // GO stuck: poll timeout clears CTRL and SS, then reports an error
    go_stuck = 1'b1;
    push_xip_start(32'h0300_0300);
    push_w(5'h10, 32'd0);
    push_w(5'h18, 32'd0);
    apb_check("xip_timeout", 32'h3000_0300, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1, w);
    go_stuck = 1'b0;
`endif

    repeat (4) @(posedge clock);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
